if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with PC, IF/ID register and one-entry stall buffer
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4,
  output logic        VALID
);

  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] branch_pc;
  logic [31:0] reset_pc_aligned;
  logic        accept;

  assign branch_pc        = BRANCH_TARGET & ~32'd3;
  assign reset_pc_aligned = RESET_PC & ~32'd3;
  assign accept           = (state == S_FETCH) && !IMEM_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_next;
  end

  // A taken branch always restarts fetching, whatever the hazard unit asks for.
  always_comb begin
    state_next = state;
    if (BRANCH_TAKEN) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (accept && STALL) state_next = S_HOLD;
        S_HOLD:  if (!STALL)          state_next = S_FETCH;
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    IMEM_READ    = (state == S_FETCH);
    IMEM_ADDRESS = pc;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc          <= reset_pc_aligned;
      buf_instr   <= NOP_INSTR;
      INSTRUCTION <= NOP_INSTR;
      PC_OUT      <= RESET_PC;
      VALID       <= 1'b0;
    end else if (BRANCH_TAKEN) begin
      pc          <= branch_pc;
      buf_instr   <= NOP_INSTR;
      INSTRUCTION <= NOP_INSTR;
      VALID       <= 1'b0;
    end else if (state == S_HOLD) begin
      // The PC did not move while holding, so it is still the buffered word's PC.
      if (!STALL) begin
        INSTRUCTION <= buf_instr;
        PC_OUT      <= pc;
        VALID       <= 1'b1;
        pc          <= pc + 32'd4;
      end
    end else if (!accept) begin
      if (!STALL) begin
        INSTRUCTION <= NOP_INSTR;
        VALID       <= 1'b0;
      end
    end else if (STALL) begin
      buf_instr <= IMEM_READDATA;
    end else begin
      INSTRUCTION <= IMEM_READDATA;
      PC_OUT      <= pc;
      VALID       <= 1'b1;
      pc          <= pc + 32'd4;
    end
  end

  assign PC_PLUS4 = PC_OUT + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scenario and randomized checks of if_stage against a behavioural model
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4;
  logic        VALID;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc, m_instr, m_pcout, m_buf;
  logic        m_valid, m_holding;

  if_stage dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
    .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT), .PC_PLUS4(PC_PLUS4), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h00A00093;
    if (a == 32'd4) return 32'h00108113;
    return {a[29:2], 4'hB};
  endfunction

  assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

  // Drive one cycle of inputs, advance the model, and sample just after the edge.
  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [31:0] t, input logic w);
    RESET = r; STALL = s; BRANCH_TAKEN = b; BRANCH_TARGET = t; IMEM_BUSYWAIT = w;
    if (r) begin
      m_pc = 32'd0; m_holding = 1'b0; m_instr = NOP; m_pcout = 32'd0; m_valid = 1'b0;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_holding = 1'b0; m_instr = NOP; m_valid = 1'b0;
    end else if (m_holding) begin
      if (!s) begin
        m_instr = m_buf; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_holding = 1'b0;
      end
    end else if (w) begin
      if (!s) begin m_instr = NOP; m_valid = 1'b0; end
    end else if (s) begin
      m_holding = 1'b1; m_buf = mem_word(m_pc);
    end else begin
      m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 1, 1, 32'h40, 0);
    cyc(1, 0, 0, 0, 1);
    n_cmp++; if (INSTRUCTION !== NOP) begin n_err++; $display("FAIL reset_instr got %h want %h", INSTRUCTION, NOP); end
    n_cmp++; if (VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", VALID); end
    n_cmp++; if (PC_OUT !== 32'd0) begin n_err++; $display("FAIL reset_pcout got %h want 0", PC_OUT); end
    n_cmp++; if (IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 32'd0) begin
      n_err++; $display("FAIL reset_fetch got read=%b addr=%h want read=1 addr=0", IMEM_READ, IMEM_ADDRESS); end
  endtask

  task automatic test_sequential;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (INSTRUCTION !== 32'h00A00093 || PC_OUT !== 32'd0 || PC_PLUS4 !== 32'd4 || VALID !== 1'b1) begin
      n_err++; $display("FAIL seq_word0 got %h/%h/%h/%b want 00a00093/0/4/1", INSTRUCTION, PC_OUT, PC_PLUS4, VALID); end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (INSTRUCTION !== 32'h00108113 || PC_OUT !== 32'd4 || PC_PLUS4 !== 32'd8 || VALID !== 1'b1) begin
      n_err++; $display("FAIL seq_word1 got %h/%h/%h/%b want 00108113/4/8/1", INSTRUCTION, PC_OUT, PC_PLUS4, VALID); end
  endtask

  task automatic test_busywait;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      n_cmp++; if (INSTRUCTION !== NOP || VALID !== 1'b0 || IMEM_ADDRESS !== 32'd8) begin
        n_err++; $display("FAIL busy_bubble%0d got %h/%b addr %h want %h/0 addr 8", i, INSTRUCTION, VALID, IMEM_ADDRESS, NOP); end
    end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (INSTRUCTION !== mem_word(32'd8) || PC_OUT !== 32'd8 || VALID !== 1'b1) begin
      n_err++; $display("FAIL busy_release got %h/%h/%b want %h/8/1", INSTRUCTION, PC_OUT, VALID, mem_word(32'd8)); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 0);
      n_cmp++; if (INSTRUCTION !== mem_word(32'd8) || PC_OUT !== 32'd8 || IMEM_READ !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d got %h/%h read=%b want %h/8 read=0", i, INSTRUCTION, PC_OUT, IMEM_READ, mem_word(32'd8)); end
    end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (INSTRUCTION !== mem_word(32'd12) || PC_OUT !== 32'd12 || IMEM_ADDRESS !== 32'd16 || IMEM_READ !== 1'b1) begin
      n_err++; $display("FAIL stall_release got %h/%h addr %h want %h/c addr 10", INSTRUCTION, PC_OUT, IMEM_ADDRESS, mem_word(32'd12)); end
  endtask

  task automatic test_branch_in_hold;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 32'h00000103, 0);
    n_cmp++; if (IMEM_ADDRESS !== 32'h100 || IMEM_READ !== 1'b1 || VALID !== 1'b0 || INSTRUCTION !== NOP) begin
      n_err++; $display("FAIL branch_hold got addr %h read=%b %h/%b want addr 100 read=1 %h/0", IMEM_ADDRESS, IMEM_READ, INSTRUCTION, VALID, NOP); end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (INSTRUCTION !== mem_word(32'h100) || PC_OUT !== 32'h100 || VALID !== 1'b1) begin
      n_err++; $display("FAIL branch_target_word got %h/%h/%b want %h/100/1", INSTRUCTION, PC_OUT, VALID, mem_word(32'h100)); end
  endtask

  task automatic test_wrap;
    cyc(0, 0, 1, 32'hFFFFFFFC, 0);
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (PC_OUT !== 32'hFFFFFFFC || PC_PLUS4 !== 32'd0 || IMEM_ADDRESS !== 32'd0 || VALID !== 1'b1) begin
      n_err++; $display("FAIL wrap got pcout %h plus4 %h addr %h valid %b want fffffffc/0/0/1", PC_OUT, PC_PLUS4, IMEM_ADDRESS, VALID); end
  endtask

  task automatic test_reset_midwait;
    logic seen20;
    seen20 = 1'b0;
    cyc(0, 0, 1, 32'd20, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    n_cmp++; if (IMEM_ADDRESS !== 32'd0 || VALID !== 1'b0 || INSTRUCTION !== NOP || PC_OUT !== 32'd0) begin
      n_err++; $display("FAIL reset_midwait got addr %h %h/%b pcout %h want 0 %h/0 pcout 0", IMEM_ADDRESS, INSTRUCTION, VALID, PC_OUT, NOP); end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, (i < 2) ? 1'b1 : 1'b0);
      if (VALID === 1'b1 && PC_OUT === 32'd20) seen20 = 1'b1;
    end
    n_cmp++; if (seen20 !== 1'b0) begin n_err++; $display("FAIL reset_discard got word@20 delivered want none"); end
  endtask

  task automatic test_random;
    logic r, s, b, w;
    logic [31:0] t;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 63) == 0);
      b = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(r, s, b, t, w);
      n_cmp++; if (IMEM_READ !== !m_holding || IMEM_ADDRESS !== m_pc) begin
        n_err++; $display("FAIL rnd_fetch cyc %0d got read=%b addr=%h want read=%b addr=%h", i, IMEM_READ, IMEM_ADDRESS, !m_holding, m_pc); end
      n_cmp++; if (INSTRUCTION !== m_instr || VALID !== m_valid) begin
        n_err++; $display("FAIL rnd_ifid cyc %0d got %h/%b want %h/%b", i, INSTRUCTION, VALID, m_instr, m_valid); end
      n_cmp++; if (PC_OUT !== m_pcout || PC_PLUS4 !== m_pcout + 32'd4) begin
        n_err++; $display("FAIL rnd_pc cyc %0d got %h/%h want %h/%h", i, PC_OUT, PC_PLUS4, m_pcout, m_pcout + 32'd4); end
    end
  endtask

  initial begin
    m_pc = 0; m_instr = NOP; m_pcout = 0; m_buf = NOP; m_valid = 0; m_holding = 0;
    @(posedge CLK);
    #1;
    test_reset();
    test_sequential();
    test_busywait();
    test_stall();
    test_branch_in_hold();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
